// File: rtl/mtap_pkg.sv
// Shared definitions for the clocked joypad multitap.
//   MTAP_MAX_PORTS   : largest supported NPORTS
//   MTAP_IDX_W       : width of the scan index / PORT_IDX output
//   MTAP_OVF_DEFAULT : default data returned once the scan runs past the last port
//   mtap_state_e     : scan FSM states
//   port_slice(k,dw) : LSB position of port k inside the packed pad bus
package mtap_pkg;

  localparam int MTAP_MAX_PORTS = 8;
  localparam int MTAP_IDX_W = 4;
  localparam logic [3:0] MTAP_OVF_DEFAULT = 4'b0000;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_OVF  = 1'b1
  } mtap_state_e;

  function automatic int unsigned port_slice(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/mtap_sync_edge.sv
// Synchroniser for one host control line plus rising-edge detect.
//   clk_i   : system clock
//   reset_i : synchronous active-high reset, clears the whole chain
//   async_i : host signal, asynchronous to clk_i
//   sync_o  : async_i after STAGES flops
//   rise_o  : one-cycle pulse when sync_o goes 0 -> 1
module mtap_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] chain_q;
  logic              last_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chain_q <= '0;
      last_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
      last_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/upd65005_mtap_sync.sv
// Clocked joypad multitap. Synchronises host SEL/CLR, steps a scan index on every
// SEL rise, fans SEL/CLR out to the pads and returns the selected pad's nibble on a
// registered output. Past the last port the index saturates and OVF_VAL is returned.
// In bypass only port 0 is connected.
//   clk_i       : system clock
//   reset_i     : synchronous active-high reset
//   host_clr_i  : host CLR (async)
//   host_sel_i  : host SEL (async)
//   bypass_i    : 1 = port 0 passthrough, index held at 0
//   d_out_o     : registered data to host
//   pd_i        : pad data, port k at [k*DW +: DW]
//   p_clr_o     : per-port CLR
//   p_sel_o     : per-port SEL (1 = idle)
//   port_idx_o  : current scan index, NPORTS means overflow
//
// state   | meaning
// --------+-----------------------------------------------
// ST_SCAN | idx < NPORTS, a pad is selected
// ST_OVF  | idx == NPORTS, no pad selected, SEL rises hold
module upd65005_mtap_sync
  import mtap_pkg::*;
#(
  parameter int NPORTS = 5,
  parameter int DW = 4,
  parameter int SYNC_STAGES = 2,
  parameter logic [DW-1:0] OVF_VAL = DW'(MTAP_OVF_DEFAULT)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    host_clr_i,
  input  logic                    host_sel_i,
  input  logic                    bypass_i,
  output logic [DW-1:0]           d_out_o,
  input  logic [NPORTS*DW-1:0]    pd_i,
  output logic [NPORTS-1:0]       p_clr_o,
  output logic [NPORTS-1:0]       p_sel_o,
  output logic [MTAP_IDX_W-1:0]   port_idx_o
);

  localparam logic [MTAP_IDX_W-1:0] LAST_IDX = MTAP_IDX_W'(NPORTS);

  logic clr_s, clr_rise_unused;
  logic sel_s, sel_rise;

  mtap_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (host_clr_i),
    .sync_o  (clr_s),
    .rise_o  (clr_rise_unused)
  );

  mtap_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sel (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (host_sel_i),
    .sync_o  (sel_s),
    .rise_o  (sel_rise)
  );

  logic [DW-1:0] pad_w [NPORTS];

  for (genvar k = 0; k < NPORTS; k++) begin : g_pad
    assign pad_w[k] = pd_i[port_slice(k, DW) +: DW];
  end

  mtap_state_e             state_q, state_d;
  logic [MTAP_IDX_W-1:0]   idx_q, idx_d;
  logic [DW-1:0]           d_out_q, d_out_d;
  logic [NPORTS-1:0]       p_clr_q, p_clr_d;
  logic [NPORTS-1:0]       p_sel_q, p_sel_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    // CLR is level-dominant, so a SEL rise in the same cycle is discarded.
    if (bypass_i || clr_s) begin
      idx_d   = '0;
      state_d = ST_SCAN;
    end else if (sel_rise) begin
      unique case (state_q)
        ST_SCAN: begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q + 1'b1 == LAST_IDX) ? ST_OVF : ST_SCAN;
        end
        default: ;
      endcase
    end

    // Fan-out uses the next index so P_SEL lines up with PORT_IDX.
    p_sel_d = '1;
    p_clr_d = '0;
    if (bypass_i) begin
      p_sel_d[0] = sel_s;
      p_clr_d[0] = clr_s;
    end else begin
      p_clr_d = {NPORTS{clr_s}};
      for (int k = 0; k < NPORTS; k++) begin
        if (idx_d == MTAP_IDX_W'(k)) p_sel_d[k] = sel_s;
      end
    end

    // Output mux samples the current index, giving the extra register stage.
    d_out_d = OVF_VAL;
    if (bypass_i) begin
      d_out_d = pad_w[0];
    end else if (state_q == ST_SCAN) begin
      for (int k = 0; k < NPORTS; k++) begin
        if (idx_q == MTAP_IDX_W'(k)) d_out_d = pad_w[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_SCAN;
      idx_q   <= '0;
      d_out_q <= OVF_VAL;
      p_clr_q <= '0;
      p_sel_q <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_out_q <= d_out_d;
      p_clr_q <= p_clr_d;
      p_sel_q <= p_sel_d;
    end
  end

  assign d_out_o    = d_out_q;
  assign p_clr_o    = p_clr_q;
  assign p_sel_o    = p_sel_q;
  assign port_idx_o = idx_q;

endmodule

// File: tb/tb_upd65005_mtap_sync.sv
module tb_upd65005_mtap_sync;

  logic clk = 1'b0;
  logic reset, host_clr, host_sel, bypass;

  logic [3:0]  d5, d3, d8;
  logic [19:0] pd5, pd3;
  logic [31:0] pd8;
  logic [4:0]  pclr5, psel5, pclr3, psel3;
  logic [7:0]  pclr8, psel8;
  logic [3:0]  idx5, idx3, idx8;

  logic [7:0] pad5 [5];
  logic [7:0] pad8 [8];

  int total = 0;
  int bad = 0;

  // reference model: host levels and number of counted SEL rises per pad count
  int   m_idx5, m_idx8;
  logic m_clr, m_sel, m_byp;

  always #5 clk = ~clk;

  // pads return the high nibble while selected (SEL=0), low nibble otherwise
  always_comb begin
    pd5 = '0;
    pd3 = '0;
    pd8 = '0;
    for (int k = 0; k < 5; k++) begin
      pd5[k*4 +: 4] = psel5[k] ? pad5[k][3:0] : pad5[k][7:4];
      pd3[k*4 +: 4] = psel3[k] ? pad5[k][3:0] : pad5[k][7:4];
    end
    for (int k = 0; k < 8; k++)
      pd8[k*4 +: 4] = psel8[k] ? pad8[k][3:0] : pad8[k][7:4];
  end

  upd65005_mtap_sync #(.NPORTS(5), .DW(4), .SYNC_STAGES(2)) dut5 (
    .clk_i(clk), .reset_i(reset), .host_clr_i(host_clr), .host_sel_i(host_sel),
    .bypass_i(bypass), .d_out_o(d5), .pd_i(pd5), .p_clr_o(pclr5), .p_sel_o(psel5),
    .port_idx_o(idx5));

  upd65005_mtap_sync #(.NPORTS(5), .DW(4), .SYNC_STAGES(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .host_clr_i(host_clr), .host_sel_i(host_sel),
    .bypass_i(bypass), .d_out_o(d3), .pd_i(pd3), .p_clr_o(pclr3), .p_sel_o(psel3),
    .port_idx_o(idx3));

  upd65005_mtap_sync #(.NPORTS(8), .DW(4), .SYNC_STAGES(2)) dut8 (
    .clk_i(clk), .reset_i(reset), .host_clr_i(host_clr), .host_sel_i(host_sel),
    .bypass_i(bypass), .d_out_o(d8), .pd_i(pd8), .p_clr_o(pclr8), .p_sel_o(psel8),
    .port_idx_o(idx8));

  function automatic logic [7:0] pad_of(int n, int i);
    if (n == 8) return pad8[i];
    return pad5[i];
  endfunction

  function automatic logic [3:0] nib(logic [7:0] b, logic s);
    return s ? b[3:0] : b[7:4];
  endfunction

  function automatic logic [3:0] exp_dout(int n, int idx);
    if (m_byp) return nib(pad_of(n, 0), m_sel);
    if (idx < n) return nib(pad_of(n, idx), m_sel);
    return 4'h0;
  endfunction

  function automatic logic [7:0] exp_psel(int n, int idx);
    logic [7:0] r;
    r = 8'hFF;
    if (m_byp) r[0] = m_sel;
    else if (idx < n) r[idx] = m_sel;
    return r;
  endfunction

  function automatic logic [7:0] exp_pclr(int n);
    logic [7:0] r;
    r = 8'h00;
    if (m_byp) r[0] = m_clr;
    else for (int k = 0; k < n; k++) r[k] = m_clr;
    return r;
  endfunction

  // drive new host levels, update the model, then let all pipelines settle
  task automatic host(input logic clr, input logic sel, input logic byp);
    logic rise;
    @(negedge clk);
    rise = sel && !m_sel;
    host_clr = clr;
    host_sel = sel;
    bypass = byp;
    m_clr = clr;
    m_sel = sel;
    m_byp = byp;
    if (clr || byp) begin
      m_idx5 = 0;
      m_idx8 = 0;
    end else if (rise) begin
      if (m_idx5 < 5) m_idx5++;
      if (m_idx8 < 8) m_idx8++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    host_clr = 1'b0;
    host_sel = 1'b0;
    bypass = 1'b0;
    m_clr = 1'b0; m_sel = 1'b0; m_byp = 1'b0;
    m_idx5 = 0; m_idx8 = 0;
    repeat (3) @(negedge clk);
    total++; if (d5 !== 4'h0) begin bad++; $display("FAIL reset_dout got %h exp 0", d5); end
    total++; if (idx5 !== 4'h0) begin bad++; $display("FAIL reset_idx got %0d exp 0", idx5); end
    total++; if (psel5 !== 5'b11111) begin bad++; $display("FAIL reset_psel got %b exp 11111", psel5); end
    total++; if (pclr5 !== 5'b00000) begin bad++; $display("FAIL reset_pclr got %b exp 00000", pclr5); end
    total++; if (psel8 !== 8'hFF) begin bad++; $display("FAIL reset_psel8 got %b exp 11111111", psel8); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_scan();
    logic [3:0] exp_seq [10];
    exp_seq = '{4'h7, 4'hE, 4'hB, 4'hD, 4'hD, 4'hB, 4'hE, 4'h7, 4'hC, 4'h6};
    host(0, 1, 0);
    host(1, 1, 0);
    host(0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) host(0, (i % 2) == 0, 0);
      total++;
      if (d5 !== exp_seq[i]) begin
        bad++; $display("FAIL scan_dout step %0d got %h exp %h", i, d5, exp_seq[i]);
      end
      total++;
      if (idx5 !== 4'(i / 2)) begin
        bad++; $display("FAIL scan_idx step %0d got %0d exp %0d", i, idx5, i / 2);
      end
    end
  endtask

  task automatic test_overflow();
    host(0, 1, 0);
    total++; if (idx5 !== 4'd5) begin bad++; $display("FAIL ovf_idx got %0d exp 5", idx5); end
    total++; if (d5 !== 4'h0) begin bad++; $display("FAIL ovf_dout got %h exp 0", d5); end
    total++; if (psel5 !== 5'b11111) begin bad++; $display("FAIL ovf_psel got %b exp 11111", psel5); end
    for (int i = 0; i < 2; i++) begin
      host(0, 0, 0);
      host(0, 1, 0);
      total++; if (idx5 !== 4'd5) begin bad++; $display("FAIL ovf_hold %0d got %0d exp 5", i, idx5); end
      total++; if (d5 !== 4'h0) begin bad++; $display("FAIL ovf_hold_dout %0d got %h exp 0", i, d5); end
    end
  endtask

  task automatic test_clr_wins();
    host(1, 0, 0); host(0, 0, 0);
    host(0, 1, 0); host(0, 0, 0);
    host(0, 1, 0); host(0, 0, 0);
    total++; if (idx5 !== 4'd2) begin bad++; $display("FAIL clrw_pre_idx got %0d exp 2", idx5); end
    host(1, 1, 0);
    total++; if (idx5 !== 4'd0) begin bad++; $display("FAIL clrw_idx got %0d exp 0", idx5); end
    total++; if (d5 !== 4'h7) begin bad++; $display("FAIL clrw_dout got %h exp 7", d5); end
    total++; if (pclr5 !== 5'b11111) begin bad++; $display("FAIL clrw_pclr got %b exp 11111", pclr5); end
    host(0, 1, 0);
    total++; if (pclr5 !== 5'b00000) begin bad++; $display("FAIL clrw_pclr_rel got %b exp 00000", pclr5); end
    total++; if (idx5 !== 4'd0) begin bad++; $display("FAIL clrw_idx_rel got %0d exp 0", idx5); end
  endtask

  task automatic test_bypass();
    logic s;
    host(1, 0, 0); host(0, 0, 0);
    host(0, 1, 0); host(0, 0, 0);
    host(0, 0, 1);
    total++; if (idx5 !== 4'd0) begin bad++; $display("FAIL byp_enter_idx got %0d exp 0", idx5); end
    for (int i = 0; i < 6; i++) begin
      s = (i % 2) == 0;
      host(0, s, 1);
      total++; if (idx5 !== 4'd0) begin bad++; $display("FAIL byp_idx %0d got %0d exp 0", i, idx5); end
      total++;
      if (d5 !== (s ? 4'h7 : 4'hE)) begin
        bad++; $display("FAIL byp_dout %0d got %h exp %h", i, d5, s ? 4'h7 : 4'hE);
      end
      total++;
      if (psel5 !== {4'b1111, s}) begin
        bad++; $display("FAIL byp_psel %0d got %b exp %b", i, psel5, {4'b1111, s});
      end
    end
    host(1, 1, 1);
    total++; if (pclr5 !== 5'b00001) begin bad++; $display("FAIL byp_pclr got %b exp 00001", pclr5); end
    host(0, 0, 0);
    total++; if (d5 !== 4'hE) begin bad++; $display("FAIL byp_exit_dout got %h exp E", d5); end
  endtask

  task automatic test_latency();
    logic [3:0] old5, old3;
    int lat5, lat3;
    host(1, 0, 0);
    host(0, 0, 0);
    total++; if (d5 !== 4'hE) begin bad++; $display("FAIL lat_pre_dout got %h exp E", d5); end
    old5 = d5;
    old3 = d3;
    lat5 = 0;
    lat3 = 0;
    @(posedge clk);
    #1;
    host_sel = 1'b1;
    m_sel = 1'b1; m_idx5 = 1; m_idx8 = 1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (lat5 == 0 && d5 !== old5) lat5 = c;
      if (lat3 == 0 && d3 !== old3) lat3 = c;
    end
    total++; if (lat5 !== 4) begin bad++; $display("FAIL lat_sync2 got %0d exp 4", lat5); end
    total++; if (lat3 !== 5) begin bad++; $display("FAIL lat_sync3 got %0d exp 5", lat3); end
    total++; if (d5 !== 4'hB) begin bad++; $display("FAIL lat_post_dout got %h exp B", d5); end
    // pad data change reaches D_OUT one clock later
    pad5[1] = 8'hD5;
    @(negedge clk);
    total++; if (d5 !== 4'hB) begin bad++; $display("FAIL pad_lat_early got %h exp B", d5); end
    @(posedge clk);
    #1;
    total++; if (d5 !== 4'h5) begin bad++; $display("FAIL pad_lat got %h exp 5", d5); end
    pad5[1] = 8'hDB;
    host(0, 1, 0);
  endtask

  task automatic test_reset_mid();
    host(1, 0, 0); host(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      host(0, 1, 0);
      host(0, 0, 0);
    end
    total++; if (idx5 !== 4'd3) begin bad++; $display("FAIL rstm_pre_idx got %0d exp 3", idx5); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (idx5 !== 4'd0) begin bad++; $display("FAIL rstm_idx got %0d exp 0", idx5); end
    total++; if (d5 !== 4'h0) begin bad++; $display("FAIL rstm_dout got %h exp 0", d5); end
    total++; if (pclr5 !== 5'b00000) begin bad++; $display("FAIL rstm_pclr got %b exp 00000", pclr5); end
    total++; if (idx8 !== 4'd0) begin bad++; $display("FAIL rstm_idx8 got %0d exp 0", idx8); end
    @(negedge clk);
    reset = 1'b0;
    m_idx5 = 0; m_idx8 = 0;
    repeat (8) @(negedge clk);
    total++; if (d5 !== 4'hE) begin bad++; $display("FAIL rstm_after_dout got %h exp E", d5); end
  endtask

  task automatic test_scan8();
    logic [7:0] ep;
    host(1, 0, 0); host(0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      host(0, 1, 0);
      ep = exp_psel(8, m_idx8);
      total++;
      if (idx8 !== 4'(m_idx8)) begin bad++; $display("FAIL scan8_idx %0d got %0d exp %0d", i, idx8, m_idx8); end
      total++;
      if (d8 !== exp_dout(8, m_idx8)) begin
        bad++; $display("FAIL scan8_dout %0d got %h exp %h", i, d8, exp_dout(8, m_idx8));
      end
      total++;
      if (psel8 !== ep) begin bad++; $display("FAIL scan8_psel %0d got %b exp %b", i, psel8, ep); end
      host(0, 0, 0);
    end
    total++; if (idx8 !== 4'd8) begin bad++; $display("FAIL scan8_final got %0d exp 8", idx8); end
  endtask

  task automatic test_random();
    logic nclr, nsel, nbyp;
    logic [7:0] ep5, ec5, ep8, ec8;
    for (int i = 0; i < 60; i++) begin
      nclr = ($urandom_range(0, 5) == 0);
      nsel = 1'($urandom_range(0, 1));
      nbyp = ($urandom_range(0, 9) == 0) ? ~m_byp : m_byp;
      host(nclr, nsel, nbyp);
      ep5 = exp_psel(5, m_idx5);
      ec5 = exp_pclr(5);
      ep8 = exp_psel(8, m_idx8);
      ec8 = exp_pclr(8);
      total++;
      if (idx5 !== 4'(m_idx5)) begin bad++; $display("FAIL rnd_idx5 %0d got %0d exp %0d", i, idx5, m_idx5); end
      total++;
      if (d5 !== exp_dout(5, m_idx5)) begin
        bad++; $display("FAIL rnd_d5 %0d got %h exp %h", i, d5, exp_dout(5, m_idx5));
      end
      total++;
      if (d3 !== exp_dout(5, m_idx5)) begin
        bad++; $display("FAIL rnd_d3 %0d got %h exp %h", i, d3, exp_dout(5, m_idx5));
      end
      total++;
      if (psel5 !== ep5[4:0]) begin bad++; $display("FAIL rnd_psel5 %0d got %b exp %b", i, psel5, ep5[4:0]); end
      total++;
      if (pclr5 !== ec5[4:0]) begin bad++; $display("FAIL rnd_pclr5 %0d got %b exp %b", i, pclr5, ec5[4:0]); end
      total++;
      if (idx8 !== 4'(m_idx8)) begin bad++; $display("FAIL rnd_idx8 %0d got %0d exp %0d", i, idx8, m_idx8); end
      total++;
      if (d8 !== exp_dout(8, m_idx8)) begin
        bad++; $display("FAIL rnd_d8 %0d got %h exp %h", i, d8, exp_dout(8, m_idx8));
      end
      total++;
      if (psel8 !== ep8) begin bad++; $display("FAIL rnd_psel8 %0d got %b exp %b", i, psel8, ep8); end
      total++;
      if (pclr8 !== ec8) begin bad++; $display("FAIL rnd_pclr8 %0d got %b exp %b", i, pclr8, ec8); end
    end
  endtask

  initial begin
    pad5 = '{8'hE7, 8'hDB, 8'hBD, 8'h7E, 8'h6C};
    for (int k = 0; k < 8; k++) pad8[k] = 8'($urandom);
    test_reset();
    test_scan();
    test_overflow();
    test_clr_wins();
    test_bypass();
    test_latency();
    test_reset_mid();
    test_scan8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
